// File: rtl/mac_accum_reduce.sv
// mac_accum_reduce: sums cmd_len lane results into one AW-bit result,
// with selectable signedness and saturate-or-wrap on the final sum.
module mac_accum_reduce #(
   parameter int AW = 32,
   parameter int CW = 8,
   parameter int SW = 40
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [CW-1:0] cmd_len,
   input  logic          cmd_signed,
   input  logic          cmd_sat,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_y,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic          out_ovf
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_signed;
   logic          r_sat;
   logic [AW-1:0] r_sum;
   logic          r_ovf;

   logic [SW-1:0] w_ext;
   logic [SW-1:0] w_acc_nxt;
   logic          w_last;
   logic          w_ovf;
   logic [AW-1:0] w_res;
   logic [AW-1:0] w_smax;
   logic [AW-1:0] w_smin;
   logic [SW-AW:0] w_top;

   assign w_smax = {1'b0, {(AW-1){1'b1}}};
   assign w_smin = {1'b1, {(AW-1){1'b0}}};

   // Widen the incoming element to accumulator width per selected signedness
   always_comb begin
      w_ext = {{(SW-AW){1'b0}}, in_y};
      if (r_signed)
         w_ext = {{(SW-AW){in_y[AW-1]}}, in_y};
   end

   assign w_acc_nxt = r_acc + w_ext;
   assign w_last    = in_valid && (r_cnt == CW'(1));
   assign w_top     = w_acc_nxt[SW-1:AW-1];

   // Range check and saturate/wrap on the post-beat accumulator value
   always_comb begin
      w_ovf = 1'b0;
      w_res = w_acc_nxt[AW-1:0];
      if (r_signed)
         w_ovf = !((&w_top) || !(|w_top));
      else
         w_ovf = |w_acc_nxt[SW-1:AW];
      if (r_sat && w_ovf) begin
         if (!r_signed)
            w_res = '1;
         else if (w_acc_nxt[SW-1])
            w_res = w_smin;
         else
            w_res = w_smax;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid)
               w_next = (cmd_len == '0) ? S_EMIT : S_ACCUM;
         end
         S_ACCUM: begin
            if (w_last)
               w_next = S_EMIT;
         end
         S_EMIT: begin
            if (out_ready)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Accumulator, element count, command fields and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_signed <= 1'b0;
         r_sat    <= 1'b0;
         r_sum    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_acc    <= '0;
                  r_cnt    <= cmd_len;
                  r_signed <= cmd_signed;
                  r_sat    <= cmd_sat;
                  r_sum    <= '0;
                  r_ovf    <= 1'b0;
               end
            end
            S_ACCUM: begin
               if (in_valid) begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt - CW'(1);
                  if (w_last) begin
                     r_sum <= w_res;
                     r_ovf <= w_ovf;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready = (r_state == S_IDLE);
   assign in_ready  = (r_state == S_ACCUM);
   assign out_valid = (r_state == S_EMIT);
   assign out_sum   = r_sum;
   assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_mac_accum_reduce.sv
// tb_mac_accum_reduce: directed and randomized reduction groups checked
// against an arithmetic model of the exact sum and its AW-bit rendering.
module tb_mac_accum_reduce;

   localparam int AW = 32;
   localparam int CW = 8;
   localparam int SW = 40;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CW-1:0] cmd_len;
   logic          cmd_signed;
   logic          cmd_sat;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] in_y;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_sum;
   logic          out_ovf;

   int checks   = 0;
   int failures = 0;

   logic [AW-1:0] vals [0:255];

   mac_accum_reduce #(.AW(AW), .CW(CW), .SW(SW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_signed (cmd_signed),
      .cmd_sat    (cmd_sat),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_y       (in_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_ovf    (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input int len, input bit sg, input bit sat);
      int t;
      cmd_valid  = 1'b1;
      cmd_len    = CW'(len);
      cmd_signed = sg;
      cmd_sat    = sat;
      t = 0;
      while (!cmd_ready && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) chk("cmd_ready_timeout", 0, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_len   = CW'($urandom);
   endtask

   task automatic run_group(input string tag, input int len, input bit sg,
                            input bit sat, input bit gaps, input int stall);
      longint s;
      longint lo;
      longint hi;
      longint umax;
      bit     eo;
      logic [63:0]   sv;
      logic [AW-1:0] es;
      int t;
      s    = 0;
      lo   = -(64'sd1 <<< (AW-1));
      hi   = (64'sd1 <<< (AW-1)) - 1;
      umax = (64'sd1 <<< AW) - 1;
      for (int i = 0; i < len; i++) begin
         if (sg) s += longint'($signed(vals[i]));
         else    s += longint'({32'b0, vals[i]});
      end
      eo = sg ? (s < lo || s > hi) : (s > umax);
      sv = s;
      es = sv[AW-1:0];
      if (sat && eo) begin
         if (!sg)      es = '1;
         else if (s < 0) es = {1'b1, {(AW-1){1'b0}}};
         else          es = {1'b0, {(AW-1){1'b1}}};
      end
      send_cmd(len, sg, sat);
      for (int i = 0; i < len; i++) begin
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_y     = $urandom;
            repeat ($urandom_range(1, 2)) tick();
            chk({tag, "_acc_hold_ready"}, in_ready, 1);
         end
         in_valid = 1'b1;
         in_y     = vals[i];
         t = 0;
         while (!in_ready && t < 20) begin
            tick();
            t++;
         end
         if (t >= 20) chk({tag, "_in_ready_timeout"}, 0, 1);
         tick();
      end
      in_valid = 1'b0;
      in_y     = $urandom;
      chk({tag, "_valid_lat"}, out_valid, 1);
      chk({tag, "_in_ready_emit"}, in_ready, 0);
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
         in_valid = 1'b1;
         tick();
         chk({tag, "_stall_sum"}, out_sum, es);
         chk({tag, "_stall_valid"}, out_valid, 1);
      end
      in_valid = 1'b0;
      chk({tag, "_sum"}, out_sum, es);
      chk({tag, "_ovf"}, out_ovf, eo);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_done_valid"}, out_valid, 0);
      chk({tag, "_done_cmd_ready"}, cmd_ready, 1);
   endtask

   function automatic logic [AW-1:0] rand_val();
      logic [AW-1:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h7FFF_FFFF;
         1: v = 32'h8000_0000;
         2: v = 32'hFFFF_FFFF;
         3: v = AW'($urandom_range(0, 50));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_len    = '0;
      cmd_signed = 1'b0;
      cmd_sat    = 1'b0;
      in_valid   = 1'b0;
      in_y       = '0;
      out_ready  = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_ovf", out_ovf, 0);
      rst = 1'b0;
      tick();

      in_valid = 1'b1;
      in_y     = 32'h1234_5678;
      repeat (3) tick();
      chk("idle_ignore_in_ready", in_ready, 0);
      chk("idle_ignore_valid", out_valid, 0);
      in_valid = 1'b0;

      vals[0] = 32'd10;
      vals[1] = -32'sd3;
      vals[2] = 32'd7;
      vals[3] = 32'd1;
      run_group("sum4", 4, 1'b1, 1'b0, 1'b0, 0);
      chk("sum4_const", out_sum, 15);

      vals[0] = 32'h7FFF_FFFF;
      vals[1] = 32'h0000_0002;
      run_group("spos_sat", 2, 1'b1, 1'b1, 1'b0, 0);
      run_group("spos_wrap", 2, 1'b1, 1'b0, 1'b0, 0);

      vals[0] = 32'hFFFF_FFFF;
      vals[1] = 32'hFFFF_FFFF;
      vals[2] = 32'hFFFF_FFFF;
      run_group("usat", 3, 1'b0, 1'b1, 1'b0, 0);

      vals[0] = 32'h8000_0000;
      vals[1] = 32'h8000_0000;
      run_group("sneg_sat", 2, 1'b1, 1'b1, 1'b0, 1);

      run_group("len0", 0, 1'b1, 1'b1, 1'b0, 2);

      vals[0] = 32'd100;
      vals[1] = 32'd200;
      vals[2] = 32'd300;
      run_group("gap_stall", 3, 1'b0, 1'b0, 1'b1, 5);

      for (int i = 0; i < 255; i++) vals[i] = 32'hFFFF_FFFF;
      run_group("u255", 255, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 255; i++) vals[i] = 32'h8000_0000;
      run_group("s255", 255, 1'b1, 1'b1, 1'b0, 0);

      vals[0] = 32'd9;
      vals[1] = 32'd9;
      send_cmd(4, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_y     = vals[i];
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_cmd_ready", cmd_ready, 1);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_no_valid", out_valid, 0);
      end
      chk("post_rst_sum", out_sum, 0);
      vals[0] = 32'd5;
      run_group("after_rst", 1, 1'b0, 1'b0, 1'b0, 0);
      chk("after_rst_const", out_sum, 5);

      for (int g = 0; g < 25; g++) begin
         int n;
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++) vals[i] = rand_val();
         run_group("rand", n, 1'($urandom), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
